// File: rtl/seq_div_unit_pkg.sv
// Shared types and helpers for the sequential RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  function automatic logic is_signed(div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/seq_div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
// Handshake: a request transfers on a rising edge where in_valid && in_ready; a result
// transfers on a rising edge where out_valid && out_ready; valid never waits on ready.
interface seq_div_unit_if #(
  parameter int Width = 32
);
  logic                  in_valid;
  logic                  in_ready;
  div_pkg::div_op_t      op;
  logic [Width-1:0]      dividend;
  logic [Width-1:0]      divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [Width-1:0]      result;
  logic                  dz;

  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, dz
  );

  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result, dz
  );
endinterface

// File: rtl/seq_div_unit_sub_step.sv
// One restoring-division step: shift the next quotient bit into the partial remainder
// and subtract the divisor when it fits.
module div_sub_step #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] q_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] shifted;
  logic             fits;

  // rem_i[Width-1] is the carry out of the shift; when set the shifted value exceeds any
  // Width-bit divisor, and the low bits minus d_i are still the exact difference.
  always_comb begin
    shifted = {rem_i[Width-2:0], q_i[Width-1]};
    fits    = rem_i[Width-1] | (shifted >= d_i);
    rem_o   = fits ? (shifted - d_i) : shifted;
    q_o     = {q_i[Width-2:0], fits};
  end
endmodule

// File: rtl/seq_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one trial subtraction per clock.
module seq_div_unit
  import div_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  seq_div_unit_if.slave        bus,
  output div_state_t           state_o
);
  localparam int CntW = $clog2(Width) + 1;
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  div_op_t          op_q, op_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] dmag_q, dmag_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [Width-1:0] result_q, result_d;
  logic             dz_q, dz_d;

  logic [Width-1:0] step_rem, step_q;
  logic             a_neg, b_neg;

  div_sub_step #(.Width(Width)) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .d_i   (dmag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    rem_d    = rem_q;
    dmag_d   = dmag_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    dz_d     = dz_q;
    a_neg    = is_signed(op_q) && a_q[Width-1];
    b_neg    = is_signed(op_q) && b_q[Width-1];

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          state_d = PREP;
          op_d    = bus.op;
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          dz_d    = 1'b0;
        end
      end
      PREP: begin
        if (b_q == '0) begin
          result_d = is_rem(op_q) ? a_q : '1;
          dz_d     = 1'b1;
          state_d  = DONE;
        end else if (is_signed(op_q) && (a_q == MinVal) && (b_q == '1)) begin
          result_d = is_rem(op_q) ? '0 : MinVal;
          state_d  = DONE;
        end else begin
          q_d     = a_neg ? -a_q : a_q;
          dmag_d  = b_neg ? -b_q : b_q;
          rem_d   = '0;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          cnt_d   = CntW'(Width - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        q_d   = step_q;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        result_d = is_rem(op_q) ? (rsign_q ? -rem_q : rem_q)
                                : (qsign_q ? -q_q : q_q);
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pipeline kill beats both the result handoff and a new accept.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= DIV;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      dmag_q   <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      dmag_q   <= dmag_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.dz        = dz_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// Bench for seq_div_unit: directed vector table, corner sequences, and random ops
// checked against an arithmetic reference model.
module tb_seq_div_unit;
  import div_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic       clk;
  logic       rst_n;
  logic       flush;
  div_state_t state;

  seq_div_unit_if #(.Width(W)) bus ();

  seq_div_unit #(.Width(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus.slave),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: plain integer division with RISC-V M special cases
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic dz, output int lat);
    longint x, y, qv, rv;
    logic sgn, rem;
    sgn = (op == 2'd0) || (op == 2'd2);
    rem = op[1];
    dz  = 1'b0;
    lat = 35;
    if (b == 0) begin
      dz  = 1'b1;
      lat = 2;
      r   = rem ? a : 32'hFFFF_FFFF;
    end else if (sgn && a == MIN && b == 32'hFFFF_FFFF) begin
      lat = 2;
      r   = rem ? 32'h0 : MIN;
    end else begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'h0, a});
        y = longint'({32'h0, b});
      end
      qv = x / y;
      rv = x % y;
      r  = rem ? rv[W-1:0] : qv[W-1:0];
    end
  endtask

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = div_op_t'(op);
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat0, output logic [W-1:0] r, output logic d, output int lat);
    lat = lat0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
    r = bus.result;
    d = bus.dz;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] er, input logic edz,
                             input int elat);
    logic [W-1:0] r;
    logic d;
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    issue(op, a, b);
    wait_result(0, r, d, lat);
    check({name, "_result"}, r, er);
    check({name, "_dz"}, 32'(d), 32'(edz));
    check({name, "_latency"}, 32'(lat), 32'(elat));
    take();
  endtask

  initial begin
    logic [W-1:0] r, er;
    logic d, edz;
    int lat, elat, seen;

    bus.in_valid  = 1'b0;
    bus.op        = DIV;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rst_n         = 1'b0;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0, 35};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0, 35};
    vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 35};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 35};
    vecs[4]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 35};
    vecs[5]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 2};
    vecs[6]  = '{2'd3, 32'h1234,       32'd0,          32'h1234,       1'b1, 2};
    vecs[7]  = '{2'd0, MIN,            32'hFFFF_FFFF,  MIN,            1'b0, 2};
    vecs[8]  = '{2'd2, MIN,            32'hFFFF_FFFF,  32'd0,          1'b0, 2};
    vecs[9]  = '{2'd1, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0, 35};
    vecs[10] = '{2'd3, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0, 35};
    vecs[11] = '{2'd0, MIN,            32'd1,          MIN,            1'b0, 35};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_dz",        32'(bus.dz),        32'd0);
    check("rst_state",     32'(state),         32'(IDLE));
    rst_n = 1'b1;

    foreach (vecs[i])
      run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_r, vecs[i].exp_dz, vecs[i].exp_lat);

    // busy-time in_valid pulses are ignored, then out_ready held low for 10 cycles
    issue(2'd1, 32'd1000, 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.dividend = $urandom;
      bus.divisor  = 32'd1;
    end
    bus.in_valid = 1'b0;
    wait_result(10, r, d, lat);
    check("bp_latency", 32'(lat), 32'd35);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result",    bus.result,         32'd333);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    take();
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("bp_no_phantom", 32'(seen), 32'd0);

    // flush in CALC
    issue(2'd1, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    check("flush_pre_state", 32'(state), 32'(CALC));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_state",     32'(state),         32'(IDLE));
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // flush beats an accept in the same cycle
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = DIVU;
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    @(posedge clk);
    #1 begin flush = 1'b0; bus.in_valid = 1'b0; end
    check("flush_accept_state", 32'(state), 32'(IDLE));

    // flush beats out_ready in DONE
    issue(2'd0, 32'd5, 32'd0);
    wait_result(0, r, d, lat);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; bus.out_ready = 1'b0; end
    check("flush_done_valid", 32'(bus.out_valid), 32'd0);

    // async reset mid-CALC
    issue(2'd0, 32'hFFFF_FF00, 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result",    bus.result,         32'd0);
    check("midrst_dz",        32'(bus.dz),        32'd0);
    check("midrst_state",     32'(state),         32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_checked("post_rst", 2'd0, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 1'b0, 35);

    // randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      int mode;
      op   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = MIN; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
      else if (mode == 3) b = $urandom_range(1, 7) | (b & 32'h8000_0000);
      model(op, a, b, er, edz, elat);
      exp_q.push_back(er);
      issue(op, a, b);
      wait_result(0, r, d, lat);
      check($sformatf("rnd%0d_result", n), r, exp_q.pop_front());
      check($sformatf("rnd%0d_dz", n), 32'(d), 32'(edz));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d_hold", n), 32'(bus.out_valid), 32'd1);
      take();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
